// File: rtl/ex_stage.sv
// ex_stage: execute stage plus EX/MEM pipeline register.
// Forwards operands from MEM/WB, runs the ALU, resolves branches and jumps,
// and registers results toward MEM. It also owns the data-memory request FSM,
// so each memory op is issued exactly once even across stalls.
// Ports: ID/EX fields in; WB forwarding in; dmem request/response;
// redirect (combinational); ex_stall; EX/MEM register outputs.
module ex_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iHit,
    input  logic              flush,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              branch,
    input  logic              branchSel,
    input  logic              regWrite,
    input  logic              MemtoReg,
    input  logic              aluSrc,
    input  logic              HALT,
    input  logic [1:0]        PCSel,
    input  logic [3:0]        ALUop,
    input  logic [WORD_W-1:0] Imm,
    input  logic [WORD_W-1:0] pcp4,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic [25:0]       JumpAddr,
    input  logic [REG_W-1:0]  wsel,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic              wb_regWrite,
    input  logic [REG_W-1:0]  wb_wsel,
    input  logic [WORD_W-1:0] wb_wdat,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              ex_stall,
    output logic [WORD_W-1:0] aluResult_out,
    output logic [WORD_W-1:0] store_out,
    output logic [WORD_W-1:0] pcp4_out,
    output logic [WORD_W-1:0] dload_out,
    output logic [REG_W-1:0]  wsel_out,
    output logic              regWrite_out,
    output logic              MemtoReg_out,
    output logic              dREN_out,
    output logic              dWEN_out,
    output logic              halt_out
);

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} mstate_t;

    mstate_t           state, state_nxt;
    logic              adv;
    logic              mem_new;
    logic              taken;
    logic [WORD_W-1:0] fa, fb, alu_b, alu_res;
    logic [4:0]        shamt;

    assign ex_stall = (state == REQ) & ~dhit;
    assign adv      = iHit & ~ex_stall & ~halt_out;
    // A flushed slot becomes a bubble, so it never starts a memory op.
    assign mem_new  = ~flush & (dREN | dWEN);

    // Only ALU results are forwarded from MEM; load data is handled by an
    // upstream load-use stall.
    always_comb begin
        if (regWrite_out && !MemtoReg_out && wsel_out != '0 && wsel_out == rs)
            fa = aluResult_out;
        else if (wb_regWrite && wb_wsel != '0 && wb_wsel == rs)
            fa = wb_wdat;
        else
            fa = rdat1;

        if (regWrite_out && !MemtoReg_out && wsel_out != '0 && wsel_out == rt)
            fb = aluResult_out;
        else if (wb_regWrite && wb_wsel != '0 && wb_wsel == rt)
            fb = wb_wdat;
        else
            fb = rdat2;
    end

    always_comb begin
        alu_b = aluSrc ? Imm : fb;
        shamt = Imm[10:6];
        case (ALUop)
            ALU_SLL:  alu_res = fb << shamt;
            ALU_SRL:  alu_res = fb >> shamt;
            ALU_ADD:  alu_res = fa + alu_b;
            ALU_SUB:  alu_res = fa - alu_b;
            ALU_AND:  alu_res = fa & alu_b;
            ALU_OR:   alu_res = fa | alu_b;
            ALU_XOR:  alu_res = fa ^ alu_b;
            ALU_NOR:  alu_res = ~(fa | alu_b);
            ALU_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(fa) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(WORD_W-1){1'b0}}, fa < alu_b};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        taken = branch & (branchSel ? (fa != fb) : (fa == fb));
        case (PCSel)
            2'd1:    redirect_pc = pcp4 + (Imm << 2);
            2'd2:    redirect_pc = {pcp4[31:28], JumpAddr, 2'b00};
            2'd3:    redirect_pc = fa;
            default: redirect_pc = pcp4;
        endcase
        redirect = adv & ~flush & ((taken & (PCSel == 2'd1)) | (PCSel == 2'd2) | (PCSel == 2'd3));
    end

    // EX/MEM register
    always_ff @(posedge CLK) begin
        if (RST) begin
            aluResult_out <= '0;
            store_out     <= '0;
            pcp4_out      <= '0;
            dload_out     <= '0;
            wsel_out      <= '0;
            regWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            dREN_out      <= 1'b0;
            dWEN_out      <= 1'b0;
            halt_out      <= 1'b0;
        end else begin
            if (adv) begin
                if (flush) begin
                    aluResult_out <= '0;
                    store_out     <= '0;
                    pcp4_out      <= '0;
                    wsel_out      <= '0;
                    regWrite_out  <= 1'b0;
                    MemtoReg_out  <= 1'b0;
                    dREN_out      <= 1'b0;
                    dWEN_out      <= 1'b0;
                    halt_out      <= 1'b0;
                end else begin
                    aluResult_out <= alu_res;
                    store_out     <= fb;
                    pcp4_out      <= pcp4;
                    wsel_out      <= wsel;
                    regWrite_out  <= regWrite;
                    MemtoReg_out  <= MemtoReg;
                    dREN_out      <= dREN;
                    dWEN_out      <= dWEN;
                    halt_out      <= HALT;
                end
            end
            if (state == REQ && dhit)
                dload_out <= dload;
        end
    end

    // Memory FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Memory FSM: next state. DONE keeps a completed op from being replayed
    // while the pipeline is still held by a fetch miss.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (adv) state_nxt = mem_new ? REQ : IDLE;
            REQ: begin
                if (dhit) begin
                    if (adv) state_nxt = mem_new ? REQ : IDLE;
                    else     state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory FSM: outputs
    always_comb begin
        dmemREN   = (state == REQ) & dREN_out;
        dmemWEN   = (state == REQ) & dWEN_out;
        dmemaddr  = aluResult_out;
        dmemstore = store_out;
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam logic [3:0] A_SLL = 4'd0, A_ADD = 4'd2, A_SUB = 4'd3, A_NOR = 4'd7,
                           A_SLT = 4'd8, A_SLTU = 4'd9;

    logic        CLK = 1'b0, RST, iHit, flush;
    logic        dREN, dWEN, branch, branchSel, regWrite, MemtoReg, aluSrc, HALT;
    logic [1:0]  PCSel;
    logic [3:0]  ALUop;
    logic [31:0] Imm, pcp4, rdat1, rdat2;
    logic [25:0] JumpAddr;
    logic [4:0]  wsel, rs, rt;
    logic        wb_regWrite;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        dhit;
    logic [31:0] dload;
    logic        dmemREN, dmemWEN, redirect, ex_stall;
    logic [31:0] dmemaddr, dmemstore, redirect_pc;
    logic [31:0] aluResult_out, store_out, pcp4_out, dload_out;
    logic [4:0]  wsel_out;
    logic        regWrite_out, MemtoReg_out, dREN_out, dWEN_out, halt_out;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage dut (
        .CLK(CLK), .RST(RST), .iHit(iHit), .flush(flush),
        .dREN(dREN), .dWEN(dWEN), .branch(branch), .branchSel(branchSel),
        .regWrite(regWrite), .MemtoReg(MemtoReg), .aluSrc(aluSrc), .HALT(HALT),
        .PCSel(PCSel), .ALUop(ALUop), .Imm(Imm), .pcp4(pcp4),
        .rdat1(rdat1), .rdat2(rdat2), .JumpAddr(JumpAddr),
        .wsel(wsel), .rs(rs), .rt(rt),
        .wb_regWrite(wb_regWrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .dhit(dhit), .dload(dload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .redirect(redirect), .redirect_pc(redirect_pc), .ex_stall(ex_stall),
        .aluResult_out(aluResult_out), .store_out(store_out), .pcp4_out(pcp4_out),
        .dload_out(dload_out), .wsel_out(wsel_out), .regWrite_out(regWrite_out),
        .MemtoReg_out(MemtoReg_out), .dREN_out(dREN_out), .dWEN_out(dWEN_out),
        .halt_out(halt_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic nop();
        dREN = 0; dWEN = 0; branch = 0; branchSel = 0; regWrite = 0; MemtoReg = 0;
        aluSrc = 0; HALT = 0; PCSel = 0; ALUop = A_ADD; Imm = 0; pcp4 = 0;
        rdat1 = 0; rdat2 = 0; JumpAddr = 0; wsel = 0; rs = 0; rt = 0;
    endtask

    // Register-free ALU op (sources 10/11 never match a forwarding destination)
    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src);
        nop();
        ALUop = op; rdat1 = a; rdat2 = b; Imm = imm; aluSrc = src; rs = 10; rt = 11;
    endtask

    initial begin
        nop();
        RST = 1; iHit = 0; flush = 0; wb_regWrite = 0; wb_wsel = 0; wb_wdat = 0;
        dhit = 0; dload = 0;
        tick(); tick();
        chk("rst_alu", aluResult_out, 0);
        chk("rst_store", store_out, 0);
        chk("rst_pcp4", pcp4_out, 0);
        chk("rst_dload", dload_out, 0);
        chk("rst_ctrl", {wsel_out, regWrite_out, MemtoReg_out, dREN_out, dWEN_out, halt_out}, 0);
        chk("rst_dmem", {dmemREN, dmemWEN, ex_stall}, 0);

        // First advance: ADD 5 + 7
        RST = 0; iHit = 1;
        nop(); ALUop = A_ADD; rdat1 = 5; rdat2 = 7; rs = 1; rt = 2; wsel = 3; regWrite = 1;
        pcp4 = 32'h24;
        tick();
        chk("add_first", aluResult_out, 12);
        chk("add_store", store_out, 7);
        chk("add_wsel", wsel_out, 3);
        chk("add_pcp4", pcp4_out, 32'h24);

        // Forwarding: EX/MEM r3=100, WB r3=55
        nop(); rdat1 = 100; aluSrc = 1; rs = 5; rt = 6; wsel = 3; regWrite = 1;
        tick();
        chk("fwd_setup", aluResult_out, 100);
        wb_regWrite = 1; wb_wsel = 3; wb_wdat = 55;
        nop(); rs = 3; rt = 6; rdat1 = 1; Imm = 1; aluSrc = 1; wsel = 7; regWrite = 1;
        tick();
        chk("fwd_mem_first", aluResult_out, 101);
        tick();
        chk("fwd_wb", aluResult_out, 56);
        // Register 0 is never forwarded
        nop(); rdat1 = 200; aluSrc = 1; rs = 5; wsel = 0; regWrite = 1;
        tick();
        chk("r0_setup", wsel_out, 0);
        wb_wsel = 0; wb_wdat = 55;
        nop(); rs = 0; rdat1 = 9; Imm = 1; aluSrc = 1; regWrite = 1;
        tick();
        chk("fwd_r0", aluResult_out, 10);
        wb_regWrite = 0;

        // ALU ops
        alu(A_SUB, 3, 5, 0, 0); tick();
        chk("sub_wrap", aluResult_out, 32'hFFFF_FFFE);
        alu(A_SLT, 32'hFFFF_FFFF, 1, 0, 0); tick();
        chk("slt_signed", aluResult_out, 1);
        alu(A_SLTU, 32'hFFFF_FFFF, 1, 0, 0); tick();
        chk("sltu", aluResult_out, 0);
        alu(A_SLL, 0, 1, 32'h0000_0100, 0); tick();
        chk("sll_4", aluResult_out, 16);
        alu(A_NOR, 32'hF0F0_0000, 32'h0000_00FF, 0, 0); tick();
        chk("nor", aluResult_out, 32'h0F0F_FF00);

        // Branches / jumps (combinational)
        alu(A_SUB, 4, 4, 0, 0); branch = 1; branchSel = 1; PCSel = 1;
        pcp4 = 32'h100; Imm = 32'hFFFF_FFFF;
        #1 chk("bne_equal", redirect, 0);
        branchSel = 0;
        #1 chk("beq_redir", redirect, 1);
        chk("beq_target", redirect_pc, 32'h0000_00FC);
        iHit = 0;
        #1 chk("beq_no_adv", redirect, 0);
        iHit = 1; branch = 0; PCSel = 3; rdat1 = 32'h400;
        #1 chk("jr_redir", redirect, 1);
        chk("jr_target", redirect_pc, 32'h400);
        PCSel = 2; pcp4 = 32'hA000_0000; JumpAddr = 26'h10;
        #1 chk("j_target", redirect_pc, 32'hA000_0040);
        flush = 1;
        #1 chk("j_flushed", redirect, 0);
        flush = 0;
        tick();

        // Load with 3-cycle miss
        nop(); dREN = 1; MemtoReg = 1; regWrite = 1; rdat1 = 32'h40; Imm = 4; aluSrc = 1;
        wsel = 8; rs = 10;
        tick();
        chk("lw_ren", dmemREN, 1);
        chk("lw_addr", dmemaddr, 32'h44);
        chk("lw_stall", ex_stall, 1);
        nop(); rdat1 = 1; Imm = 1; aluSrc = 1; wsel = 9; regWrite = 1; rs = 10; PCSel = 3;
        flush = 1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_redir", redirect, 0);
            tick();
            chk("stall_hold", aluResult_out, 32'h44);
            chk("stall_wsel", wsel_out, 8);
            chk("stall_out", ex_stall, 1);
        end
        iHit = 0; dhit = 1; dload = 32'hDEAD;
        tick();
        dhit = 0;
        chk("done_ren", dmemREN, 0);
        chk("done_stall", ex_stall, 0);
        chk("done_dload", dload_out, 32'hDEAD);
        chk("done_hold", aluResult_out, 32'h44);
        tick();
        chk("no_replay", dmemREN, 0);
        iHit = 1;
        #1 chk("flush_redir", redirect, 0);
        tick();
        chk("bubble_rw", regWrite_out, 0);
        chk("bubble_alu", aluResult_out, 0);
        chk("bubble_dload", dload_out, 32'hDEAD);
        chk("bubble_ren", dmemREN, 0);
        flush = 0;

        // Store, completing with dhit while advancing
        nop(); dWEN = 1; rdat1 = 32'h80; rdat2 = 32'h77; rs = 10; rt = 11; aluSrc = 1;
        tick();
        chk("sw_wen", dmemWEN, 1);
        chk("sw_data", dmemstore, 32'h77);
        chk("sw_addr", dmemaddr, 32'h80);
        nop(); dhit = 1;
        tick();
        dhit = 0;
        chk("sw_idle", {dmemWEN, dmemREN, ex_stall}, 0);

        // Reset during a request
        nop(); dREN = 1; MemtoReg = 1; rdat1 = 32'h40; aluSrc = 1; rs = 10;
        tick();
        chk("lw2_ren", dmemREN, 1);
        RST = 1;
        tick();
        chk("rst_req_ren", dmemREN, 0);
        chk("rst_req_alu", aluResult_out, 0);
        RST = 0; iHit = 0;
        tick();
        chk("rst_idle", {ex_stall, dmemREN}, 0);

        // Halt freezes everything
        iHit = 1;
        nop(); HALT = 1; rdat1 = 32'h33; aluSrc = 1; rs = 10;
        tick();
        chk("halt_set", halt_out, 1);
        nop(); rdat1 = 5; rdat2 = 5; regWrite = 1; wsel = 3; rs = 10; rt = 11; PCSel = 2;
        dREN = 1;
        for (int i = 0; i < 12; i++) tick();
        chk("halt_sticky", halt_out, 1);
        chk("halt_frozen", aluResult_out, 32'h33);
        chk("halt_no_req", {dmemREN, regWrite_out}, 0);
        chk("halt_redir", redirect, 0);
        RST = 1;
        tick();
        chk("halt_cleared", halt_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
